// File: rtl/cmp_debounce_counter.sv
// Debounces the comparator's G/E/L class: a new relation commits only after HOLD consecutive
// valid samples. Counts commits per class and flags malformed flag combinations.
module cmp_debounce_counter #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned CW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          G,
  input  logic          E,
  input  logic          L,
  input  logic          clr,
  output logic [1:0]    state,
  output logic          state_valid,
  output logic          change,
  output logic [CW-1:0] gt_count,
  output logic [CW-1:0] eq_count,
  output logic [CW-1:0] lt_count,
  output logic          err
);

  localparam int unsigned RW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

  localparam logic [1:0] ClsEq = 2'b00;
  localparam logic [1:0] ClsGt = 2'b01;
  localparam logic [1:0] ClsLt = 2'b10;

  logic [1:0]    state_q, state_d;
  logic          state_valid_q, state_valid_d;
  logic          change_q, change_d;
  logic [1:0]    cand_q, cand_d;
  logic [RW-1:0] run_q, run_d;
  logic [CW-1:0] gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic          err_q, err_d;

  logic [1:0]    cls;
  logic          legal;
  logic [RW-1:0] run_nxt;

  always_comb begin
    cls   = ClsEq;
    legal = 1'b0;
    case ({G, E, L})
      3'b100:  begin cls = ClsGt; legal = 1'b1; end
      3'b010:  begin cls = ClsEq; legal = 1'b1; end
      3'b001:  begin cls = ClsLt; legal = 1'b1; end
      default: begin cls = ClsEq; legal = 1'b0; end
    endcase
  end

  // A run only continues if the candidate matches and progress has actually been made.
  assign run_nxt = (cls == cand_q && run_q != '0) ? run_q + RW'(1) : RW'(1);

  always_comb begin
    state_d       = state_q;
    state_valid_d = state_valid_q;
    change_d      = 1'b0;
    cand_d        = cand_q;
    run_d         = run_q;
    gt_d          = gt_q;
    eq_d          = eq_q;
    lt_d          = lt_q;
    err_d         = err_q;

    if (clr) begin
      state_d       = ClsEq;
      state_valid_d = 1'b0;
      cand_d        = ClsEq;
      run_d         = '0;
      gt_d          = '0;
      eq_d          = '0;
      lt_d          = '0;
      err_d         = 1'b0;
    end else if (in_valid) begin
      if (!legal) begin
        err_d = 1'b1;
        run_d = '0;
      end else if (state_valid_q && cls == state_q) begin
        run_d = '0;
      end else begin
        cand_d = cls;
        if (run_nxt == RW'(HOLD)) begin
          state_d       = cls;
          state_valid_d = 1'b1;
          change_d      = 1'b1;
          run_d         = '0;
          case (cls)
            ClsGt:   if (gt_q != '1) gt_d = gt_q + CW'(1);
            ClsLt:   if (lt_q != '1) lt_d = lt_q + CW'(1);
            default: if (eq_q != '1) eq_d = eq_q + CW'(1);
          endcase
        end else begin
          run_d = run_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ClsEq;
      state_valid_q <= 1'b0;
      change_q      <= 1'b0;
      cand_q        <= ClsEq;
      run_q         <= '0;
      gt_q          <= '0;
      eq_q          <= '0;
      lt_q          <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      state_valid_q <= state_valid_d;
      change_q      <= change_d;
      cand_q        <= cand_d;
      run_q         <= run_d;
      gt_q          <= gt_d;
      eq_q          <= eq_d;
      lt_q          <= lt_d;
      err_q         <= err_d;
    end
  end

  assign state       = state_q;
  assign state_valid = state_valid_q;
  assign change      = change_q;
  assign gt_count    = gt_q;
  assign eq_count    = eq_q;
  assign lt_count    = lt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cmp_debounce_counter.sv
// Directed bench: HOLD=4/CW=8 instance for the main behaviour, HOLD=1/CW=2 for saturation.
module tb_cmp_debounce_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       va = 1'b0, ga = 1'b0, ea = 1'b0, la = 1'b0, clra = 1'b0;
  logic [1:0] st_a;
  logic       sv_a, ch_a, err_a;
  logic [7:0] gt_a, eq_a, lt_a;

  logic       vb = 1'b0, gb = 1'b0, eb = 1'b0, lb = 1'b0, clrb = 1'b0;
  logic [1:0] st_b;
  logic       sv_b, ch_b, err_b;
  logic [1:0] gt_b, eq_b, lt_b;

  int total = 0;
  int bad   = 0;

  cmp_debounce_counter #(.HOLD(4), .CW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .G(ga), .E(ea), .L(la), .clr(clra),
    .state(st_a), .state_valid(sv_a), .change(ch_a),
    .gt_count(gt_a), .eq_count(eq_a), .lt_count(lt_a), .err(err_a)
  );

  cmp_debounce_counter #(.HOLD(1), .CW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .G(gb), .E(eb), .L(lb), .clr(clrb),
    .state(st_b), .state_valid(sv_b), .change(ch_b),
    .gt_count(gt_b), .eq_count(eq_b), .lt_count(lt_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [1:0] st, input logic sv, input logic ch,
                      input logic [7:0] gt, input logic [7:0] eq, input logic [7:0] lt,
                      input logic er);
    chk({tag, ".state"}, 32'(st_a), 32'(st));
    chk({tag, ".valid"}, 32'(sv_a), 32'(sv));
    chk({tag, ".change"}, 32'(ch_a), 32'(ch));
    chk({tag, ".gt"}, 32'(gt_a), 32'(gt));
    chk({tag, ".eq"}, 32'(eq_a), 32'(eq));
    chk({tag, ".lt"}, 32'(lt_a), 32'(lt));
    chk({tag, ".err"}, 32'(err_a), 32'(er));
  endtask

  // One clock on dut_a with the given sample; outputs are checked #1 after the edge.
  task automatic stepa(input logic v, input logic g, input logic e, input logic l);
    va = v; ga = g; ea = e; la = l;
    @(posedge clk);
    #1;
    va = 1'b0; ga = 1'b0; ea = 1'b0; la = 1'b0;
  endtask

  task automatic stepb(input logic v, input logic g, input logic e, input logic l);
    vb = v; gb = g; eb = e; lb = l;
    @(posedge clk);
    #1;
    vb = 1'b0; gb = 1'b0; eb = 1'b0; lb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chka("reset", 2'b00, 0, 0, 0, 0, 0, 0);
    chk("reset_b.valid", 32'(sv_b), 0);
    rst_n = 1'b1;

    // Four G samples commit to greater
    stepa(1, 1, 0, 0);
    stepa(1, 1, 0, 0);
    stepa(1, 1, 0, 0);
    chka("g3", 2'b00, 0, 0, 0, 0, 0, 0);
    stepa(1, 1, 0, 0);
    chka("g4", 2'b01, 1, 1, 1, 0, 0, 0);
    stepa(0, 0, 0, 0);
    chka("g4_after", 2'b01, 1, 0, 1, 0, 0, 0);

    // L,L,L,E breaks the run; four more L commit to less
    stepa(1, 0, 0, 1);
    stepa(1, 0, 0, 1);
    stepa(1, 0, 0, 1);
    stepa(1, 0, 1, 0);
    chka("lll_e", 2'b01, 1, 0, 1, 0, 0, 0);
    stepa(1, 0, 0, 1);
    stepa(1, 0, 0, 1);
    stepa(1, 0, 0, 1);
    chka("l7", 2'b01, 1, 0, 1, 0, 0, 0);
    stepa(1, 0, 0, 1);
    chka("l8", 2'b10, 1, 1, 1, 0, 1, 0);

    // Idle cycles neither advance nor break a run
    stepa(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) stepa(0, 0, 1, 0);
    stepa(1, 0, 1, 0);
    stepa(1, 0, 1, 0);
    chka("gap3", 2'b10, 1, 0, 1, 0, 1, 0);
    stepa(1, 0, 1, 0);
    chka("gap4", 2'b00, 1, 1, 1, 1, 1, 0);

    // Illegal sample mid-run sets err and restarts the run
    stepa(1, 1, 0, 0);
    stepa(1, 1, 0, 0);
    stepa(1, 1, 1, 0);
    chka("illegal", 2'b00, 1, 0, 1, 1, 1, 1);
    stepa(1, 1, 0, 0);
    stepa(1, 1, 0, 0);
    stepa(1, 1, 0, 0);
    chka("ill_g3", 2'b00, 1, 0, 1, 1, 1, 1);
    stepa(1, 1, 0, 0);
    chka("ill_g4", 2'b01, 1, 1, 2, 1, 1, 1);

    // clr with a sample present clears everything and discards the sample
    clra = 1'b1;
    stepa(1, 0, 0, 1);
    clra = 1'b0;
    chka("clr", 2'b00, 0, 0, 0, 0, 0, 0);
    stepa(0, 1, 1, 1);
    chk("idle_illegal.err", 32'(err_a), 0);

    // Saturation on the HOLD=1, CW=2 instance
    for (int i = 1; i <= 10; i++) begin
      if (i % 2 == 1) stepb(1, 1, 0, 0);
      else            stepb(1, 0, 1, 0);
      chk($sformatf("sat%0d.state", i), 32'(st_b), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("sat%0d.change", i), 32'(ch_b), 32'd1);
      chk($sformatf("sat%0d.gt", i), 32'(gt_b), ((i + 1) / 2 > 3) ? 32'd3 : 32'((i + 1) / 2));
      chk($sformatf("sat%0d.eq", i), 32'(eq_b), (i / 2 > 3) ? 32'd3 : 32'(i / 2));
    end
    stepb(1, 0, 1, 0);
    chk("sat_same.change", 32'(ch_b), 0);
    stepb(1, 0, 0, 1);
    chk("sat_lt.lt", 32'(lt_b), 1);
    chk("sat_lt.state", 32'(st_b), 2);

    // Async reset mid-run
    for (int i = 0; i < 4; i++) stepa(1, 0, 0, 1);
    chka("pre_rst", 2'b10, 1, 1, 0, 0, 1, 0);
    stepa(1, 1, 0, 0);
    stepa(1, 1, 0, 0);
    stepa(1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chka("async_rst", 2'b00, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    stepa(1, 1, 0, 0);
    chka("post_rst_g1", 2'b00, 0, 0, 0, 0, 0, 0);
    stepa(1, 1, 0, 0);
    stepa(1, 1, 0, 0);
    stepa(1, 1, 0, 0);
    chka("post_rst_g4", 2'b01, 1, 1, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
